sd_sector_fifo: RTL

Byte buffer that sits directly downstream of the SD card reader top level. It accepts the reader's `fifo_data_in`/`fifo_push` byte stream, stores it in an on-chip FIFO, and presents it to a consumer using first-word-fall-through pop semantics. It also frames the stream into sectors: it counts accepted bytes, pulses once per complete sector, and keeps sticky error flags for overflow and underflow.

---
 rtl/sd_sector_fifo.sv | 110 +++++++++++
 1 files changed

// File: rtl/sd_sector_fifo.sv
// rtl/sd_sector_fifo.sv - Byte FIFO with first-word-fall-through read and sector framing
//
// Purpose: buffers the SD reader byte stream in an on-chip FIFO, presents the
// head byte combinationally, counts accepted bytes into fixed-size sectors and
// keeps sticky overflow/underflow flags.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   clear             synchronous flush, same effect as reset (memory kept)
//   data_in, push     byte stream from the reader, one byte per cycle
//   pop               consumer acknowledge of the head byte
//   data_out          head byte, meaningful only while empty is low
//   empty, full       occupancy is 0 / DEPTH
//   count             occupancy 0..DEPTH
//   sector_done       one-cycle pulse after the last byte of a sector is accepted
//   sector_count      completed sectors, wraps modulo 2^16
//   overflow          sticky, a push was rejected
//   underflow         sticky, a pop was rejected
module sd_sector_fifo #(
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = 10,
    parameter int SECTOR_BYTES = 512
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic [7:0]        data_in,
    input  logic              push,
    input  logic              pop,
    output logic [7:0]        data_out,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              sector_done,
    output logic [15:0]       sector_count,
    output logic              overflow,
    output logic              underflow
);

    localparam int BC_W = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [BC_W-1:0] LAST_BYTE  = BC_W'(SECTOR_BYTES - 1);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [BC_W-1:0]   byte_cnt;
    logic              flush;
    logic              acc_push;
    logic              acc_pop;
    logic              sector_end;

    assign flush    = reset | clear;
    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign acc_push = push & (~full | pop);
    assign acc_pop  = pop & ~empty;
    assign sector_end = acc_push & (byte_cnt == LAST_BYTE);
    assign data_out = mem[rd_ptr];

    // Storage has no reset; a flush only rewinds the pointers.
    always_ff @(posedge clock) begin
        if (acc_push && !flush) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            byte_cnt     <= '0;
            sector_count <= '0;
            sector_done  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (acc_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (acc_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (acc_push && !acc_pop) begin
                count <= count + 1'b1;
            end else if (acc_pop && !acc_push) begin
                count <= count - 1'b1;
            end

            // Only accepted bytes advance the sector position.
            if (sector_end) begin
                byte_cnt     <= '0;
                sector_count <= sector_count + 16'd1;
            end else if (acc_push) begin
                byte_cnt <= byte_cnt + 1'b1;
            end
            sector_done <= sector_end;

            if (push && !acc_push) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule
